// File: rtl/fetch_unit_if.sv
// Decode-side fetch handshake plus branch redirect, grouped as one bundle.
// A transfer occurs on a rising edge where out_valid and out_ready are both 1.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus_4;
    logic [XLEN-1:0] out_instr;
    logic            out_fault;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output out_valid,
        output out_pc,
        output out_pc_plus_4,
        output out_instr,
        output out_fault
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  out_valid,
        input  out_pc,
        input  out_pc_plus_4,
        input  out_instr,
        input  out_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generator, synchronous instruction memory and
// a FETCH_DEPTH-entry fetch queue feeding decode through a valid/ready handshake.
module fetch_unit #(
    parameter int                   XLEN        = 32,
    parameter int                   IMEM_DEPTH  = 256,
    parameter logic [XLEN-1:0]      RESET_PC    = '0,
    parameter int                   FETCH_DEPTH = 4,
    parameter logic [XLEN-1:0]      NOP_INSTR   = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          reset_n,
    fetch_unit_if.master                  fif,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int QW = $clog2(FETCH_DEPTH);

    logic [XLEN-1:0] mem [IMEM_DEPTH];
    logic [XLEN-1:0] rd_data;

    logic [XLEN-1:0] fetch_pc;
    logic            rsp_valid;
    logic            rsp_fault;
    logic [XLEN-1:0] rsp_pc;

    logic [XLEN-1:0] q_pc    [FETCH_DEPTH];
    logic [XLEN-1:0] q_instr [FETCH_DEPTH];
    logic            q_fault [FETCH_DEPTH];
    logic [QW-1:0]   rd_ptr;
    logic [QW-1:0]   wr_ptr;
    logic [QW:0]     count;

    logic            head_valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic            fetch_fault;
    logic [QW+1:0]   occupancy;

    assign head_valid = (count != '0);
    assign pop        = head_valid & fif.out_ready;
    assign push       = rsp_valid & ~fif.redirect_valid;

    // Occupancy counts the in-flight response so the queue can never overflow.
    assign occupancy  = {1'b0, count} + (QW+2)'(rsp_valid) - (QW+2)'(pop);
    assign issue      = ~fif.redirect_valid & (occupancy < (QW+2)'(FETCH_DEPTH));

    // Any address bit at or above log2(4*IMEM_DEPTH) puts the fetch out of range.
    assign fetch_fault = (fetch_pc[1:0] != 2'b00) | (fetch_pc[XLEN-1:AW+2] != '0);

    // Memory is never reset; read-before-write falls out of the NBA ordering.
    always_ff @(posedge clk) begin
        if (issue && !fetch_fault) begin
            rd_data <= mem[fetch_pc[AW+1:2]];
        end
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc  <= RESET_PC;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (fif.redirect_valid) begin
            fetch_pc  <= fif.redirect_pc;
            rsp_valid <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            rsp_valid <= issue;
            if (issue) begin
                rsp_pc    <= fetch_pc;
                rsp_fault <= fetch_fault;
                fetch_pc  <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    // Entry storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= rsp_pc;
            q_instr[wr_ptr] <= rsp_fault ? NOP_INSTR : rd_data;
            q_fault[wr_ptr] <= rsp_fault;
        end
    end

    assign fif.out_valid     = head_valid;
    assign fif.out_pc        = head_valid ? q_pc[rd_ptr] : '0;
    assign fif.out_pc_plus_4 = head_valid ? q_pc[rd_ptr] + XLEN'(4) : '0;
    assign fif.out_instr     = head_valid ? q_instr[rd_ptr] : '0;
    assign fif.out_fault     = head_valid ? q_fault[rd_ptr] : 1'b0;
endmodule
